imem_load_arb: RTL and testbench
================================

# imem_load_arb

Arbiter and sequencer for the processor's 64×32 instruction memory, implemented as a single-port synchronous RAM. After reset it zero-fills the whole memory, then grants the port to the CPU fetch stage. On request it hands the port to a streaming program loader: the CPU is stalled, words are written from address 0 upward, the unused tail is zero-filled, and fetch resumes.

## Interface
- `ADDR_W`, 6, RAM address width
- `DATA_W`, 32, instruction word width
- `DEPTH`, 64, number of words; must equal 2**ADDR_W
- `clk` in 1: single clock; all state changes on the rising edge
- `rst` in 1: reset, synchronous and active-high
- `fetch_req` in 1: CPU requests instruction at `fetch_addr`
- `fetch_addr` in ADDR_W: word address from PC
- `fetch_valid` out 1: `fetch_data` valid; registered
- `fetch_data` out DATA_W: equals `mem_rdata`
- `cpu_stall` out 1: high whenever the fetch stage does not own the port
- `load_start` in 1: single-cycle pulse requesting a program load
- `load_valid` in 1: loader word valid
- `load_data` in DATA_W: loader word
- `load_last` in 1: qualifies the final word of a load
- `load_ready` out 1: arbiter accepts a loader word this cycle
- `load_count` out ADDR_W+1: words accepted in the current or last load
- `load_trunc` out 1: sticky flag, load hit DEPTH without `load_last`
- `mem_en`, `mem_we` out 1: RAM enable and write enable
- `mem_addr` out ADDR_W: RAM address
- `mem_wdata` out DATA_W: RAM write data
- `mem_rdata` in DATA_W: RAM read data, one-cycle latency after `mem_en & !mem_we`

## Operation
- States: CLEAR, RUN, LOAD, FILL. Registers: `state`, `ptr[ADDR_W-1:0]`, `load_count`, `load_trunc`, `fetch_valid`.
- CLEAR: `mem_en=mem_we=1`, `mem_addr=ptr`, `mem_wdata=0`. `ptr` increments each cycle. After the write at `ptr=DEPTH-1`, `ptr` resets to 0 and the state goes to RUN.
- RUN: port is combinationally routed to fetch: `mem_en=fetch_req`, `mem_we=0`, `mem_addr=fetch_addr`, `cpu_stall=0`.
  - `load_start=1` moves the state to LOAD next cycle, with `ptr←0`, `load_count←0` and `load_trunc←0`.
  - A fetch issued in that same cycle still completes normally.
- LOAD: `cpu_stall=1`, `load_ready=1`. Write enable is `mem_en=mem_we=load_valid`, with `mem_addr=ptr` and `mem_wdata=load_data`.
  - Each accepted word (`load_valid & load_ready`) increments `ptr` and `load_count`.
  - Accepted word with `load_last=1` at `ptr<DEPTH-1`: next state FILL, `ptr` advanced.
  - Accepted word at `ptr=DEPTH-1`: next state RUN, `ptr←0`. If `load_last=0`, also `load_trunc←1`.
  - `load_last` without `load_valid` is ignored.
- FILL: same write behaviour as CLEAR, starting from the current `ptr` and ending at `DEPTH-1`, then RUN. `load_ready=0`.
- In any state other than RUN:
  - `load_start` is ignored.
  - `fetch_req` is ignored; no read is issued and `fetch_valid` stays 0.
- `fetch_valid` is next-state registered as `(state==RUN) & fetch_req`.
- `load_count` saturates at DEPTH. It holds its value after the load until the next `load_start` is accepted.
- `rst` high: `state←CLEAR`, `ptr←0`, `load_count←0`, `load_trunc←0`, `fetch_valid←0`.
  - While `rst` is high, `mem_en`, `mem_we` and `load_ready` are forced 0 combinationally.
  - A mid-load reset discards the partial load. The memory is fully re-cleared afterwards.

## Timing
- Output values while `rst` is high: `cpu_stall=1`, `fetch_valid=0`, `load_ready=0`, `mem_en=mem_we=0`, `load_count=0`, `load_trunc=0`.
- CLEAR after reset lasts exactly DEPTH cycles (64). `cpu_stall` falls in cycle 65 after `rst` deasserts.
- Fetch latency: `fetch_req` in cycle N produces `fetch_valid` and `fetch_data` in cycle N+1. Back-to-back fetches are allowed, one per cycle.
- `load_start` in cycle N:
  - `cpu_stall=1` and `load_ready=1` from cycle N+1.
  - A load of K words (K<DEPTH) followed by fill takes K loader cycles plus (DEPTH−K) fill cycles.
  - RUN resumes one cycle after the last write.
- Loader handshake: a word transfers when `load_valid & load_ready`. The loader may idle (`load_valid=0`) indefinitely in LOAD; `ptr` holds.
- `load_ready` depends only on state, never on `load_valid`.

## Test plan
- Reset then idle: `cpu_stall=1` for 64 cycles with writes of 0 to addresses 0..63 in order. Then `cpu_stall=0`, and `fetch_req` at address 5 gives `fetch_valid=1`, `fetch_data=0` the next cycle.
- Load 22 words (values 0x1000+i, `load_last` on word 21), then fetch addresses 0..63: data 0x1000..0x1015 at addresses 0..21, 0 elsewhere, `load_count=22`, `load_trunc=0`.
- Load 64 words without `load_last`: returns to RUN after word 63, `load_count=64`, `load_trunc=1`. A following 3-word load with `load_last` clears `load_trunc`.
- Loader stalls (`load_valid` low for 5 cycles) mid-load, and `fetch_req` is held high throughout: no RAM write and no `fetch_valid` during the stall, `ptr` unchanged, final contents correct.
- `load_start` and `fetch_req` (address 3) in the same RUN cycle: fetch completes with `fetch_valid=1` next cycle, and the load proceeds.
- `rst` asserted after 10 loaded words: full 64-cycle CLEAR follows, then fetching any address returns 0.

Source files
------------

// File: rtl/imem_load_arb_if.sv
// Port bundle for the instruction-memory arbiter: CPU fetch, program loader and RAM sides.
interface imem_load_arb_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_stall;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic [ADDR_W:0]   load_count;
  logic              load_trunc;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_last, mem_rdata,
    output fetch_valid, fetch_data, cpu_stall, load_ready, load_count, load_trunc,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last, mem_rdata,
    input  fetch_valid, fetch_data, cpu_stall, load_ready, load_count, load_trunc,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_load_arb.sv
// Single-port instruction RAM arbiter: clears memory after reset, serves CPU fetches,
// and hands the port to a streaming loader that writes from address 0 and zero-fills the tail.
module imem_load_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic            clk,
  input  logic            rst,
  imem_load_arb_if.slave  bus
);

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] FILL  = 2'd3;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   load_count;
  logic              load_trunc;
  logic              fetch_valid;
  logic              accept;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == CNT_MAX) ? v : v + (ADDR_W + 1)'(1);
  endfunction

  assign accept = (state == LOAD) && bus.load_valid;

  // Port mux: CLEAR/FILL write zeros at ptr, LOAD writes loader data at ptr, RUN belongs to fetch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ptr;
    mem_wdata = '0;
    case (state)
      CLEAR, FILL: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
      RUN: begin
        mem_en   = bus.fetch_req;
        mem_addr = bus.fetch_addr;
      end
      LOAD: begin
        mem_en    = bus.load_valid;
        mem_we    = bus.load_valid;
        mem_wdata = bus.load_data;
      end
      default: ;
    endcase
    if (rst) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.fetch_data  = bus.mem_rdata;
  assign bus.fetch_valid = fetch_valid;
  assign bus.cpu_stall   = rst || (state != RUN);
  assign bus.load_ready  = !rst && (state == LOAD);
  assign bus.load_count  = load_count;
  assign bus.load_trunc  = load_trunc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      ptr         <= '0;
      load_count  <= '0;
      load_trunc  <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= (state == RUN) && bus.fetch_req;
      case (state)
        CLEAR, FILL: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_LAST) begin
            ptr   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            load_count <= '0;
            load_trunc <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            ptr        <= ptr + 1'b1;
            load_count <= sat_inc(load_count);
            // Running off the end ends the load with nothing left to fill.
            if (ptr == PTR_LAST) begin
              ptr   <= '0;
              state <= RUN;
              if (!bus.load_last) load_trunc <= 1'b1;
            end else if (bus.load_last) begin
              state <= FILL;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_arb.sv
// Scoreboard bench for imem_load_arb with a behavioural synchronous RAM on the memory port.
module tb_imem_load_arb;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic [DATA_W-1:0] fetch_q [$];
  logic [DATA_W-1:0] exp_word;

  imem_load_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_load_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every fetch_valid pops the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.fetch_valid === 1'b1) begin
      if (fetch_q.size() == 0) begin
        chk("fetch_valid_unexpected", 1, 0);
      end else begin
        exp_word = fetch_q.pop_front();
        chk("fetch_data", bus.fetch_data, exp_word);
      end
    end
  end

  task automatic reset_and_clear();
    rst = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("rst_stall", bus.cpu_stall, 1);
      chk("rst_fetch_valid", bus.fetch_valid, 0);
      chk("rst_ready", bus.load_ready, 0);
      chk("rst_mem_en_we", {bus.mem_en, bus.mem_we}, 0);
      chk("rst_count", bus.load_count, 0);
      chk("rst_trunc", bus.load_trunc, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("clr_stall", bus.cpu_stall, 1);
      chk("clr_we", bus.mem_en & bus.mem_we, 1);
      chk("clr_addr", bus.mem_addr, i);
      chk("clr_wdata", bus.mem_wdata, 0);
    end
    @(negedge clk);
    chk("clr_done_stall", bus.cpu_stall, 0);
  endtask

  task automatic fetch_one(input int a);
    @(posedge clk); #1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = ADDR_W'(a);
    fetch_q.push_back(exp_mem[a]);
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
  endtask

  task automatic fetch_all();
    for (int a = 0; a < DEPTH; a++) begin
      @(posedge clk); #1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = ADDR_W'(a);
      fetch_q.push_back(exp_mem[a]);
    end
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_load(input int k, input bit with_last, input logic [DATA_W-1:0] base,
                         input int stall_at, input bit fetch_at_start);
    int n;
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    if (fetch_at_start) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = ADDR_W'(3);
      fetch_q.push_back(exp_mem[3]);
    end
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    bus.fetch_req  = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (i == stall_at) begin
        bus.load_valid = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = ADDR_W'(i);
        repeat (5) begin
          @(negedge clk);
          chk("stall_no_mem", bus.mem_en, 0);
          chk("stall_ready", bus.load_ready, 1);
          @(posedge clk); #1;
        end
        bus.fetch_req = 1'b0;
      end
      bus.load_valid = 1'b1;
      bus.load_data  = base + DATA_W'(i);
      bus.load_last  = with_last && (i == k - 1);
      @(negedge clk);
      chk("ld_stall", bus.cpu_stall, 1);
      chk("ld_ready", bus.load_ready, 1);
      chk("ld_addr", bus.mem_addr, i);
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.cpu_stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("fill_cycles", n, (k < DEPTH) ? DEPTH - k : 0);
    chk("ld_count", bus.load_count, k);
    chk("ld_trunc", bus.load_trunc, (k >= DEPTH) && !with_last);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = (i < k) ? base + DATA_W'(i) : '0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;

    reset_and_clear();
    fetch_one(5);

    do_load(22, 1'b1, 32'h1000, -1, 1'b0);
    fetch_all();

    do_load(64, 1'b0, 32'h2000, -1, 1'b0);
    fetch_all();

    do_load(3, 1'b1, 32'h3000, -1, 1'b1);
    fetch_all();

    do_load(12, 1'b1, 32'h4000, 5, 1'b0);
    fetch_all();

    // Abort a load with reset after 10 words.
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.load_data = 32'h5000 + DATA_W'(i);
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0;
    reset_and_clear();
    fetch_all();

    chk("queue_drained", fetch_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
